// File: rtl/inst_fifo_pkg.sv
// Shared definitions for the instruction fetch queue: entry layout and default depth.
package inst_fifo_pkg;

   // Default number of queue entries (power of two, at least 4).
   localparam int INST_FIFO_DEPTH = 16;

   // One fetched instruction as held in the queue.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } fifo_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Dual-issue instruction queue between fetch and decode.
// Fetch pushes up to two instructions per cycle. Decode reads the head (master)
// and head+1 (slave) combinationally and pops up to two per cycle.
// flush and rst both empty the queue. The storage array keeps stale data, and
// that data is masked by the valid flags on the way out.
module inst_fifo
   import inst_fifo_pkg::*;
#(
   parameter int DEPTH = INST_FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        wen1,
   input  logic        wen2,
   input  logic [31:0] w1_pc,
   input  logic [31:0] w1_inst,
   input  logic        w1_adel,
   input  logic [31:0] w2_pc,
   input  logic [31:0] w2_inst,
   input  logic        w2_adel,
   input  logic        master_pop,
   input  logic        slave_pop,
   output logic        master_valid,
   output logic        slave_valid,
   output logic [31:0] master_pc,
   output logic [31:0] master_inst,
   output logic        master_adel,
   output logic [31:0] slave_pc,
   output logic [31:0] slave_inst,
   output logic        slave_adel,
   output logic        full,
   output logic        empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] r_rp;
   logic [PTR_W-1:0] r_wp;
   logic [CNT_W-1:0] r_count;
   fifo_entry_t      r_mem [DEPTH];

   logic             w_push1;
   logic             w_push2;
   logic             w_pop1;
   logic             w_pop2;
   logic [1:0]       w_npush;
   logic [1:0]       w_npop;
   logic [PTR_W-1:0] w_rp1;
   logic [PTR_W-1:0] w_wp1;
   logic [CNT_W-1:0] w_count_next;
   fifo_entry_t      w_head0;
   fifo_entry_t      w_head1;

   // Status comes from the registered count only. It must never depend on same-cycle traffic.
   assign full         = (r_count > CNT_W'(DEPTH - 2));
   assign empty        = (r_count == '0);
   assign master_valid = (r_count != '0);
   assign slave_valid  = (r_count >= CNT_W'(2));

   // Slot 2 only rides along with slot 1, and a full queue refuses both slots.
   // flush discards same-cycle traffic. rst is folded in at the register and the storage write.
   assign w_push1 = wen1 & ~full & ~flush;
   assign w_push2 = w_push1 & wen2;
   assign w_pop1  = master_pop & master_valid & ~flush;
   assign w_pop2  = w_pop1 & slave_pop & slave_valid;

   assign w_npush = {w_push2, w_push1 & ~w_push2};
   assign w_npop  = {w_pop2, w_pop1 & ~w_pop2};

   assign w_rp1        = r_rp + PTR_W'(1);
   assign w_wp1        = r_wp + PTR_W'(1);
   assign w_count_next = r_count + CNT_W'(w_npush) - CNT_W'(w_npop);

   // Pointer and occupancy state. flush and rst empty the queue identically.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_rp    <= '0;
         r_wp    <= '0;
         r_count <= '0;
      end else begin
         r_rp    <= r_rp + PTR_W'(w_npop);
         r_wp    <= r_wp + PTR_W'(w_npush);
         r_count <= w_count_next;
      end
   end

   // Entry storage. It is written only for accepted pushes and is never cleared.
   always_ff @(posedge clk) begin
      if (w_push1 && !rst) begin
         r_mem[r_wp] <= '{pc: w1_pc, inst: w1_inst, adel: w1_adel};
      end
      if (w_push2 && !rst) begin
         r_mem[w_wp1] <= '{pc: w2_pc, inst: w2_inst, adel: w2_adel};
      end
   end

   assign w_head0 = r_mem[r_rp];
   assign w_head1 = r_mem[w_rp1];

   // Head read-out. An empty slot is forced to zero so stale storage never leaks to decode.
   always_comb begin
      master_pc   = '0;
      master_inst = '0;
      master_adel = 1'b0;
      slave_pc    = '0;
      slave_inst  = '0;
      slave_adel  = 1'b0;
      if (master_valid) begin
         master_pc   = w_head0.pc;
         master_inst = w_head0.inst;
         master_adel = w_head0.adel;
      end
      if (slave_valid) begin
         slave_pc   = w_head1.pc;
         slave_inst = w_head1.inst;
         slave_adel = w_head1.adel;
      end
   end

   // Simulation checks: a fetch push against a full queue is dropped, and occupancy stays in range.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(wen1 && full))
            else $warning("inst_fifo: push while full dropped");
         assert (r_count <= CNT_W'(DEPTH))
            else $error("inst_fifo: occupancy out of range");
      end
   end

endmodule
